// File: rtl/rs_ooo_station_pkg.sv
// Shared widths, ALU opcode encodings and sizing helpers for the ALU reservation station.
package rs_ooo_station_pkg;

    localparam int OP_WIDTH  = 6;
    localparam int ID_WIDTH  = 4;
    localparam int VAL_WIDTH = 32;
    localparam int RS_DEPTH  = 8;
    localparam int CDB_COUNT = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD = 6'd0,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    // Width needed to count 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rs_ooo_station_if.sv
// Issue, result-broadcast and dispatch buses of the ALU reservation station.
interface rs_ooo_station_if
    import rs_ooo_station_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int XLEN    = VAL_WIDTH,
    parameter int TAG_W   = ID_WIDTH,
    parameter int OP_W    = OP_WIDTH,
    parameter int NUM_CDB = CDB_COUNT
) ();

    logic                       issue_valid;
    logic                       issue_ready;
    logic [OP_W-1:0]            issue_op;
    logic [TAG_W-1:0]           issue_tag;
    logic [XLEN-1:0]            issue_v1;
    logic [XLEN-1:0]            issue_v2;
    logic [TAG_W-1:0]           issue_q1;
    logic [TAG_W-1:0]           issue_q2;
    logic                       issue_r1;
    logic                       issue_r2;

    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0]    cdb_val;

    logic                       disp_valid;
    logic                       disp_ready;
    logic [OP_W-1:0]            disp_op;
    logic [TAG_W-1:0]           disp_tag;
    logic [XLEN-1:0]            disp_v1;
    logic [XLEN-1:0]            disp_v2;

    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport master (
        output issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
               issue_q1, issue_q2, issue_r1, issue_r2,
               cdb_valid, cdb_tag, cdb_val, disp_ready,
        input  issue_ready, disp_valid, disp_op, disp_tag, disp_v1, disp_v2, occupancy
    );

    modport slave (
        input  issue_valid, issue_op, issue_tag, issue_v1, issue_v2,
               issue_q1, issue_q2, issue_r1, issue_r2,
               cdb_valid, cdb_tag, cdb_val, disp_ready,
        output issue_ready, disp_valid, disp_op, disp_tag, disp_v1, disp_v2, occupancy
    );

endinterface

// File: rtl/rs_ooo_station_age_picker.sv
// Oldest-ready selector: grants the ready entry that no other ready entry is older than.
module rs_age_picker #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic [$clog2(DEPTH)-1:0]    idx,
    output logic                        found
);

    localparam int IDX_W = $clog2(DEPTH);

    // older[j][i] set means entry j arrived before entry i.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_ooo_station.sv
// ALU reservation station: holds renamed instructions, snoops result buses and dispatches oldest-ready.
module rs_ooo_station
    import rs_ooo_station_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int XLEN    = VAL_WIDTH,
    parameter int TAG_W   = ID_WIDTH,
    parameter int OP_W    = OP_WIDTH,
    parameter int NUM_CDB = CDB_COUNT
) (
    input  logic           clk,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush,
    rs_ooo_station_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [DEPTH-1:0]            busy, r1, r2;
    logic [DEPTH-1:0][DEPTH-1:0] older;
    logic [OP_W-1:0]             e_op  [DEPTH];
    logic [TAG_W-1:0]            e_tag [DEPTH];
    logic [XLEN-1:0]             e_v1  [DEPTH];
    logic [XLEN-1:0]             e_v2  [DEPTH];
    logic [TAG_W-1:0]            e_q1  [DEPTH];
    logic [TAG_W-1:0]            e_q2  [DEPTH];

    logic [DEPTH-1:0]            w1_hit, w2_hit;
    logic [XLEN-1:0]             w1_val [DEPTH];
    logic [XLEN-1:0]             w2_val [DEPTH];
    logic                        b1_hit, b2_hit;
    logic [XLEN-1:0]             b1_val, b2_val;

    logic [DEPTH-1:0]            grant;
    logic [IDX_W-1:0]            sel_idx, free_idx;
    logic                        sel_found, issue_fire, disp_load;

    logic                        d_valid;
    logic [OP_W-1:0]             d_op;
    logic [TAG_W-1:0]            d_tag;
    logic [XLEN-1:0]             d_v1, d_v2;
    logic [CNT_W-1:0]            occ;

    assign bus.issue_ready = (occ != CNT_W'(DEPTH));
    assign bus.occupancy   = occ;
    assign bus.disp_valid  = d_valid;
    assign bus.disp_op     = d_op;
    assign bus.disp_tag    = d_tag;
    assign bus.disp_v1     = d_v1;
    assign bus.disp_v2     = d_v2;

    assign issue_fire = rdy_in && bus.issue_valid && bus.issue_ready;
    assign disp_load  = rdy_in && (!d_valid || bus.disp_ready) && sel_found;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    // Walk channels high to low so the lowest-indexed matching channel has the last word.
    always_comb begin
        b1_hit = 1'b0;
        b2_hit = 1'b0;
        b1_val = '0;
        b2_val = '0;
        w1_hit = '0;
        w2_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w1_val[i] = '0;
            w2_val[i] = '0;
        end
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.cdb_valid[c]) begin
                if (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.issue_q1) begin
                    b1_hit = 1'b1;
                    b1_val = bus.cdb_val[c*XLEN +: XLEN];
                end
                if (bus.cdb_tag[c*TAG_W +: TAG_W] == bus.issue_q2) begin
                    b2_hit = 1'b1;
                    b2_val = bus.cdb_val[c*XLEN +: XLEN];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.cdb_tag[c*TAG_W +: TAG_W] == e_q1[i]) begin
                        w1_hit[i] = 1'b1;
                        w1_val[i] = bus.cdb_val[c*XLEN +: XLEN];
                    end
                    if (bus.cdb_tag[c*TAG_W +: TAG_W] == e_q2[i]) begin
                        w2_hit[i] = 1'b1;
                        w2_val[i] = bus.cdb_val[c*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    rs_age_picker #(.DEPTH(DEPTH)) u_picker (
        .ready (busy & r1 & r2),
        .older (older),
        .grant (grant),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Control state: flush wins over everything else; the new entry is younger than all current ones.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            busy    <= '0;
            r1      <= '0;
            r2      <= '0;
            older   <= '0;
            d_valid <= 1'b0;
            d_op    <= '0;
            d_tag   <= '0;
            d_v1    <= '0;
            d_v2    <= '0;
            occ     <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy    <= '0;
                r1      <= '0;
                r2      <= '0;
                older   <= '0;
                d_valid <= 1'b0;
                occ     <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && !r1[i] && w1_hit[i]) r1[i] <= 1'b1;
                    if (busy[i] && !r2[i] && w2_hit[i]) r2[i] <= 1'b1;
                end
                if (disp_load) begin
                    busy    <= busy & ~grant;
                    d_valid <= 1'b1;
                    d_op    <= e_op[sel_idx];
                    d_tag   <= e_tag[sel_idx];
                    d_v1    <= e_v1[sel_idx];
                    d_v2    <= e_v2[sel_idx];
                end else if (d_valid && bus.disp_ready) begin
                    d_valid <= 1'b0;
                end
                if (issue_fire) begin
                    busy[free_idx] <= 1'b1;
                    r1[free_idx]   <= bus.issue_r1 || b1_hit;
                    r2[free_idx]   <= bus.issue_r2 || b2_hit;
                    for (int j = 0; j < DEPTH; j++) begin
                        older[j][free_idx] <= busy[j];
                        older[free_idx][j] <= 1'b0;
                    end
                end
                if (issue_fire && !disp_load) begin
                    occ <= occ + CNT_W'(1);
                end else if (!issue_fire && disp_load) begin
                    occ <= occ - CNT_W'(1);
                end
            end
        end
    end

    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy_in && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !r1[i] && w1_hit[i]) e_v1[i] <= w1_val[i];
                if (busy[i] && !r2[i] && w2_hit[i]) e_v2[i] <= w2_val[i];
            end
            if (issue_fire) begin
                e_op[free_idx]  <= bus.issue_op;
                e_tag[free_idx] <= bus.issue_tag;
                e_q1[free_idx]  <= bus.issue_q1;
                e_q2[free_idx]  <= bus.issue_q2;
                e_v1[free_idx]  <= (!bus.issue_r1 && b1_hit) ? b1_val : bus.issue_v1;
                e_v2[free_idx]  <= (!bus.issue_r2 && b2_hit) ? b2_val : bus.issue_v2;
            end
        end
    end

endmodule

// File: tb/tb_rs_ooo_station.sv
// Bench for rs_ooo_station: directed scenarios then random traffic, all checked against an age-ordered queue model.
module tb_rs_ooo_station;
    import rs_ooo_station_pkg::*;

    localparam int DEPTH   = 8;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 6;
    localparam int NUM_CDB = 2;

    logic clk    = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;
    int   tests_run = 0;
    int   fail_cnt  = 0;

    rs_ooo_station_if #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

    rs_ooo_station #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  v1, v2;
        logic [TAG_W-1:0] q1, q2;
        logic             r1, r2;
    } entry_t;

    // Waiting instructions, oldest at the front.
    entry_t           pend[$];
    logic             m_dv;
    logic [OP_W-1:0]  m_op;
    logic [TAG_W-1:0] m_tag;
    logic [XLEN-1:0]  m_v1, m_v2;

    task automatic expectEq(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic cdbLookup(input logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
        v = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == t) begin
                v = bus.cdb_val[c*XLEN +: XLEN];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        pend.delete();
        m_dv  = 1'b0;
        m_op  = '0;
        m_tag = '0;
        m_v1  = '0;
        m_v2  = '0;
    endtask

    task automatic modelStep();
        int             sel;
        int             n;
        logic [XLEN-1:0] v;
        entry_t         e;
        if (!rdy_in) return;
        if (flush) begin
            pend.delete();
            m_dv = 1'b0;
            return;
        end
        n   = pend.size();
        sel = -1;
        for (int i = 0; i < n; i++) begin
            if (pend[i].r1 && pend[i].r2) begin
                sel = i;
                break;
            end
        end
        for (int i = 0; i < n; i++) begin
            e = pend[i];
            if (!e.r1 && cdbLookup(e.q1, v)) begin e.v1 = v; e.r1 = 1'b1; end
            if (!e.r2 && cdbLookup(e.q2, v)) begin e.v2 = v; e.r2 = 1'b1; end
            pend[i] = e;
        end
        if (sel >= 0 && (!m_dv || bus.disp_ready)) begin
            m_dv  = 1'b1;
            m_op  = pend[sel].op;
            m_tag = pend[sel].tag;
            m_v1  = pend[sel].v1;
            m_v2  = pend[sel].v2;
            pend.delete(sel);
        end else if (m_dv && bus.disp_ready) begin
            m_dv = 1'b0;
        end
        if (bus.issue_valid && n < DEPTH) begin
            e.op  = bus.issue_op;
            e.tag = bus.issue_tag;
            e.q1  = bus.issue_q1;
            e.q2  = bus.issue_q2;
            e.v1  = bus.issue_v1;
            e.v2  = bus.issue_v2;
            e.r1  = bus.issue_r1;
            e.r2  = bus.issue_r2;
            if (!e.r1 && cdbLookup(e.q1, v)) begin e.v1 = v; e.r1 = 1'b1; end
            if (!e.r2 && cdbLookup(e.q2, v)) begin e.v2 = v; e.r2 = 1'b1; end
            pend.push_back(e);
        end
    endtask

    task automatic checkOutput();
        expectEq("disp_valid", bus.disp_valid, m_dv);
        expectEq("disp_op", bus.disp_op, m_op);
        expectEq("disp_tag", bus.disp_tag, m_tag);
        expectEq("disp_v1", bus.disp_v1, m_v1);
        expectEq("disp_v2", bus.disp_v2, m_v2);
        expectEq("occupancy", bus.occupancy, pend.size());
        expectEq("issue_ready", bus.issue_ready, pend.size() != DEPTH);
    endtask

    task automatic setIssue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                            input logic [XLEN-1:0] v1, input logic r1, input logic [TAG_W-1:0] q1,
                            input logic [XLEN-1:0] v2, input logic r2, input logic [TAG_W-1:0] q2);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_tag   = tag;
        bus.issue_v1    = v1;
        bus.issue_r1    = r1;
        bus.issue_q1    = q1;
        bus.issue_v2    = v2;
        bus.issue_r2    = r2;
        bus.issue_q2    = q2;
    endtask

    task automatic setCdb(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        bus.cdb_valid[ch]               = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W]  = tag;
        bus.cdb_val[ch*XLEN +: XLEN]    = val;
    endtask

    // One-shot inputs (issue, broadcast, flush) last exactly one edge.
    task automatic applyStimulus(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput();
            bus.issue_valid = 1'b0;
            bus.cdb_valid   = '0;
            flush           = 1'b0;
        end
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_tag   = '0;
        bus.issue_v1    = '0;
        bus.issue_v2    = '0;
        bus.issue_q1    = '0;
        bus.issue_q2    = '0;
        bus.issue_r1    = 1'b0;
        bus.issue_r2    = 1'b0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_val     = '0;
        bus.disp_ready  = 1'b1;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        expectEq("rst_disp_valid", bus.disp_valid, 0);
        expectEq("rst_disp_op", bus.disp_op, 0);
        expectEq("rst_disp_tag", bus.disp_tag, 0);
        expectEq("rst_disp_v1", bus.disp_v1, 0);
        expectEq("rst_occupancy", bus.occupancy, 0);
        expectEq("rst_issue_ready", bus.issue_ready, 1);
        rst_in = 1'b1;

        setIssue(ALU_ADD, 4'd3, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
        applyStimulus(1);
        expectEq("basic_occ_one", bus.occupancy, 1);
        expectEq("basic_not_yet", bus.disp_valid, 0);
        applyStimulus(1);
        expectEq("basic_valid", bus.disp_valid, 1);
        expectEq("basic_tag", bus.disp_tag, 3);
        expectEq("basic_v1", bus.disp_v1, 5);
        expectEq("basic_v2", bus.disp_v2, 7);
        expectEq("basic_occ_zero", bus.occupancy, 0);
        applyStimulus(1);
        expectEq("basic_drained", bus.disp_valid, 0);

        setIssue(ALU_SUB, 4'd2, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0);
        applyStimulus(1);
        setCdb(0, 4'd5, 32'd9);
        applyStimulus(2);
        expectEq("wake_wrong_tag", bus.disp_valid, 0);
        setCdb(1, 4'd6, 32'h100);
        applyStimulus(1);
        expectEq("wake_one_cycle", bus.disp_valid, 0);
        applyStimulus(1);
        expectEq("wake_valid", bus.disp_valid, 1);
        expectEq("wake_tag", bus.disp_tag, 2);
        expectEq("wake_v1", bus.disp_v1, 32'h100);
        expectEq("wake_v2", bus.disp_v2, 1);
        applyStimulus(1);

        setIssue(ALU_XOR, 4'd4, 32'd3, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9);
        setCdb(0, 4'd9, 32'd42);
        setCdb(1, 4'd9, 32'd99);
        applyStimulus(2);
        expectEq("bypass_valid", bus.disp_valid, 1);
        expectEq("bypass_tag", bus.disp_tag, 4);
        expectEq("bypass_v2", bus.disp_v2, 42);
        applyStimulus(1);

        bus.disp_ready = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            setIssue(ALU_OR, TAG_W'(t), XLEN'(t * 10), 1'b1, 4'd0, XLEN'(t), 1'b1, 4'd0);
            applyStimulus(1);
        end
        expectEq("full_issue_ready", bus.issue_ready, 0);
        expectEq("full_occupancy", bus.occupancy, 8);
        expectEq("full_head_tag", bus.disp_tag, 1);
        setIssue(ALU_OR, 4'd12, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        applyStimulus(1);
        expectEq("full_ignored", bus.occupancy, 8);
        bus.disp_ready = 1'b1;
        for (int t = 2; t <= 9; t++) begin
            applyStimulus(1);
            expectEq("age_order", bus.disp_tag, t);
        end
        applyStimulus(1);
        expectEq("full_drained", bus.disp_valid, 0);

        setIssue(ALU_SLT, 4'd10, 32'd0, 1'b0, 4'd13, 32'd5, 1'b1, 4'd0);
        applyStimulus(1);
        setIssue(ALU_SLTU, 4'd11, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
        applyStimulus(2);
        expectEq("young_first_tag", bus.disp_tag, 11);
        setCdb(0, 4'd13, 32'd77);
        applyStimulus(1);
        expectEq("old_waiting", bus.disp_valid, 0);
        applyStimulus(1);
        expectEq("old_tag", bus.disp_tag, 10);
        expectEq("old_v1", bus.disp_v1, 77);
        applyStimulus(1);

        bus.disp_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            setIssue(ALU_AND, TAG_W'(t), XLEN'(t), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
            applyStimulus(1);
        end
        expectEq("stall_occ", bus.occupancy, 5);
        expectEq("stall_dv", bus.disp_valid, 1);
        for (int k = 0; k < 3; k++) begin
            rdy_in = 1'b0;
            bus.disp_ready = 1'b1;
            setIssue(ALU_AND, 4'd15, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
            setCdb(0, 4'd1, 32'd5);
            applyStimulus(1);
            expectEq("frozen_occ", bus.occupancy, 5);
            expectEq("frozen_tag", bus.disp_tag, 0);
        end
        rdy_in = 1'b1;
        bus.disp_ready = 1'b0;
        flush = 1'b1;
        setIssue(ALU_AND, 4'd14, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        applyStimulus(1);
        expectEq("flush_occ", bus.occupancy, 0);
        expectEq("flush_dv", bus.disp_valid, 0);
        expectEq("flush_issue_ready", bus.issue_ready, 1);

        for (int t = 0; t < 3; t++) begin
            setIssue(ALU_ADD, TAG_W'(t + 5), 32'd8, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0);
            applyStimulus(1);
        end
        #2;
        rst_in = 1'b0;
        #1;
        expectEq("async_rst_dv", bus.disp_valid, 0);
        expectEq("async_rst_occ", bus.occupancy, 0);
        expectEq("async_rst_ready", bus.issue_ready, 1);
        modelReset();
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        bus.disp_ready = 1'b1;
        applyStimulus(4);
        expectEq("post_rst_no_disp", bus.disp_valid, 0);

        repeat (600) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            flush          = ($urandom_range(0, 49) == 0);
            bus.disp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                setIssue(OP_W'($urandom_range(0, 9)), TAG_W'($urandom), $urandom,
                         1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)),
                         $urandom, 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)));
            end
            for (int c = 0; c < NUM_CDB; c++) begin
                if ($urandom_range(0, 2) == 0) setCdb(c, TAG_W'($urandom_range(0, 7)), $urandom);
            end
            applyStimulus(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
